// File: rtl/plusarg_cfg_sequencer.sv
// plusarg_cfg_sequencer
// Walks NUM_CFG 32-bit configuration words after reset and writes each one
// to a downstream register file over a valid/ready address/data bus, then
// raises done. A start pulse in DONE replays the whole sequence.
// Optional feature: define PLUSARG_CFG_SKIP_ZERO_EN to skip words equal to 0.
module plusarg_cfg_sequencer #(
    parameter int unsigned NUM_CFG     = 4,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned START_DELAY = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_CFG*32-1:0] cfg_values,
    input  logic                  start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [31:0]           out_data,
    output logic                  done,
    output logic                  busy
);

    localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int unsigned CNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CFG - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(START_DELAY - 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic               valid_d, done_d, busy_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [31:0]        data_d;
    logic [31:0]        word_c;
    logic               skip_c;

    // Word currently selected by the index.
    assign word_c = cfg_values[32*int'(idx) +: 32];

`ifdef PLUSARG_CFG_SKIP_ZERO_EN
    assign skip_c = (word_c == 32'd0);
`else
    assign skip_c = 1'b0;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_WAIT;
            cnt       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            out_valid <= valid_d;
            out_addr  <= addr_d;
            out_data  <= data_d;
            done      <= done_d;
            busy      <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        valid_d = out_valid;
        addr_d  = out_addr;
        data_d  = out_data;
        done_d  = done;
        busy_d  = busy;

        case (state)
            S_WAIT: begin
                if (cnt == LAST_CNT) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_LOAD: begin
                if (skip_c) begin
                    // Zero word: no bus write, one cycle per skipped word.
                    if (idx == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end else begin
                    data_d  = word_c;
                    addr_d  = ADDR_W'(BASE_ADDR + 32'(idx));
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // out_valid is high throughout SEND, so ready alone completes it.
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_plusarg_cfg_sequencer.sv
// Directed bench for plusarg_cfg_sequencer: expected writes are queued as
// each sequence is launched and popped by a bus monitor on every handshake.
// Honours PLUSARG_CFG_SKIP_ZERO_EN to match the build of the design.
module tb_plusarg_cfg_sequencer;

    localparam int unsigned NUM_CFG = 4;
    localparam int unsigned ADDR_W  = 8;

`ifdef PLUSARG_CFG_SKIP_ZERO_EN
    localparam int DONE_K  = 9;
    localparam int STALL_K = 6;
    localparam int W2_K    = 6;
    localparam int NW      = 3;
`else
    localparam int DONE_K  = 10;
    localparam int STALL_K = 5;
    localparam int W2_K    = 7;
    localparam int NW      = 4;
`endif

    logic                  clock;
    logic                  reset_n;
    logic [NUM_CFG*32-1:0] cfg_values;
    logic                  start;
    logic                  out_ready;
    logic                  out_valid;
    logic [ADDR_W-1:0]     out_addr;
    logic [31:0]           out_data;
    logic                  done;
    logic                  busy;

    logic                  w_valid;
    logic [ADDR_W-1:0]     w_addr;
    logic [31:0]           w_data;
    logic                  w_done;
    logic                  w_busy;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] sb[$];
    logic [7:0]  cap[4];
    int          n_cap = 0;

    plusarg_cfg_sequencer #(
        .NUM_CFG(NUM_CFG), .ADDR_W(ADDR_W), .BASE_ADDR(32'h10), .START_DELAY(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .cfg_values(cfg_values), .start(start),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .done(done), .busy(busy)
    );

    // Second instance whose base address wraps past the top of the address space.
    plusarg_cfg_sequencer #(
        .NUM_CFG(NUM_CFG), .ADDR_W(ADDR_W), .BASE_ADDR(32'hFE), .START_DELAY(2)
    ) dut_wrap (
        .clock(clock), .reset_n(reset_n), .cfg_values(cfg_values), .start(start),
        .out_valid(w_valid), .out_ready(1'b1), .out_addr(w_addr),
        .out_data(w_data), .done(w_done), .busy(w_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit valid_at(input int k);
`ifdef PLUSARG_CFG_SKIP_ZERO_EN
        return (k == 3) || (k == 6) || (k == 8);
`else
        return (k == 3) || (k == 5) || (k == 7) || (k == 9);
`endif
    endfunction

    // Queue the writes a full sequence is expected to produce.
    task automatic push_writes();
        logic [31:0] w;
        for (int i = 0; i < int'(NUM_CFG); i++) begin
            w = cfg_values[32*i +: 32];
`ifdef PLUSARG_CFG_SKIP_ZERO_EN
            if (w == 32'd0) continue;
`endif
            sb.push_back({8'(32'h10 + i), w});
        end
    endtask

    task automatic check_timing(input int k);
        check($sformatf("valid_k%0d", k), 32'(out_valid), 32'(valid_at(k)));
        check($sformatf("done_k%0d", k), 32'(done), 32'(k >= DONE_K));
        check($sformatf("busy_k%0d", k), 32'(busy), 32'(k < DONE_K));
    endtask

    task automatic replay();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_fall", 32'(done), 32'd0);
    endtask

    // Bus monitor: compare each handshake against the scoreboard head.
    always @(negedge clock) begin
        logic [39:0] e;
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_write observed=%0h/%0h expected=none", out_addr, out_data);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(out_addr), 32'(e[39:32]));
                check("wr_data", out_data, e[31:0]);
            end
        end
        if (reset_n && w_valid && n_cap < NW) begin
            cap[n_cap] = w_addr;
            n_cap++;
        end
    end

    initial begin
        logic [7:0] wrap_exp[4];
        reset_n    = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b1;
        cfg_values = {32'h44, 32'h33, 32'h00, 32'h11};
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Plain run with out_ready held high.
        push_writes();
        reset_n = 1'b1;
        for (int k = 1; k <= DONE_K + 1; k++) begin
            tick();
            check_timing(k);
        end

        // Replay; a start pulse during SEND must be ignored.
        push_writes();
        replay();
        for (int k = 1; k <= DONE_K + 1; k++) begin
            tick();
            check_timing(k);
            start = (k == 3);
        end
        start = 1'b0;

        // Backpressure for five cycles on one word.
        push_writes();
        replay();
        for (int k = 1; k <= DONE_K + 6; k++) begin
            tick();
            check($sformatf("stall_done_k%0d", k), 32'(done), 32'(k >= DONE_K + 5));
            if (k >= STALL_K && k < STALL_K + 5) begin
                out_ready = 1'b0;
                check("stall_valid", 32'(out_valid), 32'd1);
`ifdef PLUSARG_CFG_SKIP_ZERO_EN
                check("stall_addr", 32'(out_addr), 32'h12);
                check("stall_data", out_data, 32'h33);
`else
                check("stall_addr", 32'(out_addr), 32'h11);
                check("stall_data", out_data, 32'h00);
`endif
            end else begin
                out_ready = 1'b1;
            end
        end
        out_ready = 1'b1;

        // Asynchronous reset while word 2 is in flight.
        push_writes();
        replay();
        for (int k = 1; k <= W2_K; k++) begin
            tick();
            check_timing(k);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", out_data, 32'd0);
        check("arst_addr", 32'(out_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd1);
        sb.delete();
        push_writes();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= DONE_K + 1; k++) begin
            tick();
            check_timing(k);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        // Addresses of the wrapping instance from its first run.
`ifdef PLUSARG_CFG_SKIP_ZERO_EN
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'h00; wrap_exp[2] = 8'h01; wrap_exp[3] = 8'h00;
`else
        wrap_exp[0] = 8'hFE; wrap_exp[1] = 8'hFF; wrap_exp[2] = 8'h00; wrap_exp[3] = 8'h01;
`endif
        check("wrap_count", 32'(n_cap), 32'(NW));
        for (int i = 0; i < NW; i++) begin
            check($sformatf("wrap_addr%0d", i), 32'(cap[i]), 32'(wrap_exp[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/plusarg_cfg_sequencer.md
# plusarg_cfg_sequencer

Post-reset configuration sequencer that walks a bank of NUM_CFG 32-bit simulation-time values, typically the `out` ports of `plusarg_reader` instances, and writes each one to a downstream register file over a valid/ready address/data bus. It sits between the plusarg readers and a DSP block's control registers, so a run can be configured from the command line without a host driver. After the last write it raises `done`. A `start` pulse in DONE replays the whole sequence.

## Interface
Parameters:
- NUM_CFG, 4: number of 32-bit configuration words; must be ≥1.
- ADDR_W, 8: width of the output address.
- BASE_ADDR, 0: address of word 0; word i goes to (BASE_ADDR + i) truncated to ADDR_W bits.
- START_DELAY, 2: cycles spent in WAIT before the first load; must be ≥1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_values  in  NUM_CFG*32  packed words; word i is bits [32*i+31:32*i].
- start  in  1  replay request; honoured only in DONE.
- out_valid  out  1  write request valid.
- out_ready  in  1  downstream accepts.
- out_addr  out  ADDR_W  write address.
- out_data  out  32  write data.
- done  out  1  sequence complete.
- busy  out  1  high in every state except DONE.

## Operation
States: WAIT, LOAD, SEND, DONE. Reset state is WAIT with the delay counter = 0 and the index = 0.
- WAIT: the counter increments each cycle. When the counter reaches START_DELAY-1, go to LOAD with the index = 0.
- LOAD: register `out_data` = word[index] and `out_addr` = BASE_ADDR + index (truncated). Go to SEND, except in the skip case under Configuration.
- SEND: `out_valid` = 1. `out_addr` and `out_data` stay stable until the handshake. On `out_valid && out_ready`:
  - If the index is the last one (NUM_CFG-1), go to DONE.
  - Otherwise increment the index and go to LOAD.
- DONE: `done` = 1 and `busy` = 0. If `start` = 1, go to WAIT with the counter and index cleared; `done` falls on the next edge.
- `start` is ignored in WAIT, LOAD and SEND.
- `cfg_values` is sampled only in LOAD. A change after sampling has no effect on the word in flight.
- `out_valid` is never deasserted without a handshake, except by reset.
- The index counter is clog2(NUM_CFG) bits, minimum 1 bit. It never wraps.

## Timing
- Reset values: `out_valid` = 0, `out_addr` = 0, `out_data` = 0, `done` = 0, `busy` = 1.
- Edge numbering: edge 1 is the first rising edge with `reset_n` high.
  - Edges 1..START_DELAY are spent in WAIT. LOAD is entered at edge START_DELAY.
  - `out_valid` first rises after edge START_DELAY+1.
- Each word costs one LOAD cycle plus at least one SEND cycle. With `out_ready` held high, `done` rises after edge START_DELAY + 2*NUM_CFG.
- Backpressure: each cycle of `out_ready` = 0 in SEND adds exactly one cycle.
- Reset asserted mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge. Any in-flight write is abandoned. The sequence restarts from word 0 after release.

## Configuration
- PLUSARG_CFG_SKIP_ZERO_EN defined:
  - In LOAD, a word equal to 0 is not written and `out_valid` stays low.
  - If that word is the last one, go to DONE; otherwise increment the index and remain in LOAD.
  - Each skipped word costs exactly one cycle.
- PLUSARG_CFG_SKIP_ZERO_EN undefined: every word is written, including zeros.

## Test plan
All scenarios use NUM_CFG=4, START_DELAY=2, BASE_ADDR=0x10, ADDR_W=8 and cfg_values = {0x44, 0x33, 0x00, 0x11} (word 3 down to word 0).
- Macro undefined, `out_ready` tied high -> four writes: (0x10,0x11), (0x11,0x00), (0x12,0x33), (0x13,0x44). `out_valid` first high after edge 3; `done` = 1 after edge 10; `busy` = 0 from then on.
- Macro defined, `out_ready` high -> three writes: (0x10,0x11), (0x12,0x33), (0x13,0x44). `done` high after edge 9.
- `out_ready` low for 5 cycles during word 1 -> `out_addr` = 0x11 and `out_data` = 0x00 held stable for all 5 cycles; `done` delayed by exactly 5 cycles.
- `reset_n` pulsed low while SEND for word 2 -> `out_valid` = 0 and `out_data` = 0 immediately, without a clock edge; after release the sequence restarts with (0x10,0x11).
- `start` pulsed in SEND (no effect) and then in DONE -> after the DONE pulse: `done` low on the next edge and the four writes repeat with the same timing as the first scenario.
- BASE_ADDR=0xFE -> addresses are 0xFE, 0xFF, 0x00, 0x01 (truncation to ADDR_W bits).
